// File: rtl/riscv_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_pkg
// Shared types for the imem/dmem memory-port arbiter: the arbiter FSM state,
// the grant encoding, default bus widths and a small grant helper.
// -----------------------------------------------------------------------------
package riscv_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } gnt_t;

  // The requester that is not g; used to break ties away from the last winner.
  function automatic gnt_t other_gnt(input gnt_t g);
    gnt_t r;
    if (g == GNT_IMEM) begin
      r = GNT_DMEM;
    end else begin
      r = GNT_IMEM;
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_if
// One APB link. The requester side uses modport master (drives psel, penable,
// paddr, pwrite, pwdata; receives pready, prdata); the completer side uses
// modport slave.
// -----------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (output psel, penable, paddr, pwrite, pwdata,
                  input  pready, prdata);
  modport slave  (input  psel, penable, paddr, pwrite, pwdata,
                  output pready, prdata);
endinterface

// File: rtl/riscv_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// riscv_arb_pick
// Combinational winner selection between the fetch and load/store requesters.
//   imem_req, dmem_req : pending requests (psel)
//   last_gnt           : requester served most recently (used for round-robin)
//   gnt                : chosen requester
//   gnt_vld            : at least one request pending
// Build option RISCV_MEM_ARB_RR_EN: ties alternate away from last_gnt.
// Default: ties go to dmem (fixed priority).
// -----------------------------------------------------------------------------
module riscv_arb_pick
  import riscv_mem_arbiter_pkg::*;
(
  input  logic imem_req,
  input  logic dmem_req,
  input  gnt_t last_gnt,
  output gnt_t gnt,
  output logic gnt_vld
);

`ifdef RISCV_MEM_ARB_RR_EN
  // Round-robin choice: a tie goes to whoever was not served last.
  always_comb begin
    gnt = GNT_DMEM;
    if (imem_req && dmem_req) begin
      gnt = other_gnt(last_gnt);
    end else if (imem_req) begin
      gnt = GNT_IMEM;
    end else begin
      gnt = GNT_DMEM;
    end
  end
`else
  logic unused_last_gnt_s;
  assign unused_last_gnt_s = last_gnt;

  // Fixed priority: load/store always wins a tie.
  always_comb begin
    gnt = GNT_DMEM;
    if (dmem_req) begin
      gnt = GNT_DMEM;
    end else if (imem_req) begin
      gnt = GNT_IMEM;
    end else begin
      gnt = GNT_DMEM;
    end
  end
`endif

  assign gnt_vld = imem_req | dmem_req;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one APB memory port between the fetch (imem) and load/store (dmem)
// requesters, one transfer at a time.
//   clk    : clock, rising edge
//   reset  : synchronous reset, active low
//   imem   : APB completer toward riscv_fetch      (slave modport)
//   dmem   : APB completer toward riscv_dmem       (slave modport)
//   mem    : APB requester toward unified memory  (master modport)
// Build option RISCV_MEM_ARB_RR_EN: round-robin on ties (adds a last_gnt flop);
// otherwise dmem has fixed priority.
// Each transfer is IDLE -> SETUP -> ACCESS; the winner's addr/write/wdata are
// captured in IDLE and held until the next IDLE. Completion toward the
// requester is combinational from mem.pready during ACCESS.
// -----------------------------------------------------------------------------
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_mem_arbiter_if.slave   imem,
  riscv_mem_arbiter_if.slave   dmem,
  riscv_mem_arbiter_if.master  mem
);

  arb_state_t        state_r;
  arb_state_t        state_s;
  gnt_t              gnt_r;
  gnt_t              last_gnt_s;
  gnt_t              pick_gnt_s;
  logic              pick_vld_s;
  logic [ADDR_W-1:0] paddr_r;
  logic              pwrite_r;
  logic [DATA_W-1:0] pwdata_r;
  logic [ADDR_W-1:0] sel_paddr_s;
  logic              sel_pwrite_s;
  logic [DATA_W-1:0] sel_pwdata_s;
  logic              done_s;
  logic              unused_penable_s;

  // penable from the requesters carries no information here: psel alone marks a request.
  assign unused_penable_s = imem.penable ^ dmem.penable;

  riscv_arb_pick u_pick (
    .imem_req (imem.psel),
    .dmem_req (dmem.psel),
    .last_gnt (last_gnt_s),
    .gnt      (pick_gnt_s),
    .gnt_vld  (pick_vld_s)
  );

  // Completion is gated by reset so an abandoned transfer never reports ready.
  assign done_s = (state_r == ARB_ACCESS) & mem.pready & reset;

`ifdef RISCV_MEM_ARB_RR_EN
  gnt_t last_gnt_r;

  // Remember who finished last so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_gnt_r <= GNT_IMEM;
    end else if (done_s) begin
      last_gnt_r <= gnt_r;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  assign last_gnt_s = last_gnt_r;
`else
  assign last_gnt_s = GNT_IMEM;
`endif

  // Mux the winning requester's transfer fields for capture.
  always_comb begin
    sel_paddr_s  = imem.paddr;
    sel_pwrite_s = imem.pwrite;
    sel_pwdata_s = imem.pwdata;
    if (pick_gnt_s == GNT_DMEM) begin
      sel_paddr_s  = dmem.paddr;
      sel_pwrite_s = dmem.pwrite;
      sel_pwdata_s = dmem.pwdata;
    end else begin
      sel_paddr_s  = imem.paddr;
      sel_pwrite_s = imem.pwrite;
      sel_pwdata_s = imem.pwdata;
    end
  end

  // Next-state logic for the APB phase sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_vld_s) begin
          state_s = ARB_SETUP;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_SETUP: begin
        state_s = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (mem.pready) begin
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_ACCESS;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // State register plus grant/field capture, taken only when leaving IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ARB_IDLE;
      gnt_r    <= GNT_DMEM;
      paddr_r  <= {ADDR_W{1'b0}};
      pwrite_r <= 1'b0;
      pwdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == ARB_IDLE) && pick_vld_s) begin
        gnt_r    <= pick_gnt_s;
        paddr_r  <= sel_paddr_s;
        pwrite_r <= sel_pwrite_s;
        pwdata_r <= sel_pwdata_s;
      end else begin
        gnt_r    <= gnt_r;
        paddr_r  <= paddr_r;
        pwrite_r <= pwrite_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  assign mem.psel    = (state_r != ARB_IDLE);
  assign mem.penable = (state_r == ARB_ACCESS);
  assign mem.paddr   = paddr_r;
  assign mem.pwrite  = pwrite_r;
  assign mem.pwdata  = pwdata_r;

  assign imem.pready = done_s & (gnt_r == GNT_IMEM);
  assign dmem.pready = done_s & (gnt_r == GNT_DMEM);
  assign imem.prdata = imem.pready ? mem.prdata : {DATA_W{1'b0}};
  assign dmem.prdata = dmem.pready ? mem.prdata : {DATA_W{1'b0}};

endmodule
